// File: rtl/instr_mem_sync.sv
// Fetch-stage instruction memory: registered read with stall hold, alignment/range
// fault detection, run-time program load port and a post-reset clear sweep.
module instr_mem_sync #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 10,
  parameter int unsigned       DEPTH        = 256,
  parameter logic [DATA_W-1:0] NOP_WORD     = '0,
  parameter bit                CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [15:0]       prog_count,
  output logic              busy
);

  localparam int unsigned       OFS        = $clog2(DATA_W / 8);
  localparam int unsigned       IDX_W      = ADDR_W - OFS;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFS) - 1);
  localparam logic [IDX_W:0]    DEPTH_L    = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    PROG
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RST ? CLEAR : RUN;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  sweep_cnt;
  logic [IDX_W-1:0]  fetch_idx, prog_idx;
  logic              fetch_ok, prog_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  assign fetch_idx = IDX_W'(fetch_addr >> OFS);
  assign prog_idx  = IDX_W'(prog_addr >> OFS);
  assign fetch_ok  = ((fetch_addr & ALIGN_MASK) == '0) && ({1'b0, fetch_idx} < DEPTH_L);
  assign prog_ok   = ((prog_addr & ALIGN_MASK) == '0) && ({1'b0, prog_idx} < DEPTH_L);

  assign busy        = (state_q == CLEAR);
  assign fetch_ready = (state_q == RUN) && !stall && !prog_en;

  // Single RAM port: CLEAR and PROG own the write path, RUN only reads.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_idx   = sweep_cnt;
    mem_wdata = NOP_WORD;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (sweep_cnt == LAST_IDX) state_d = RUN;
      end
      RUN: begin
        if (prog_en) state_d = PROG;
      end
      PROG: begin
        if (prog_we && prog_ok) begin
          mem_we    = 1'b1;
          mem_idx   = prog_idx;
          mem_wdata = prog_data;
        end
        if (!prog_en) state_d = RUN;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= RESET_STATE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      fetch_err   <= 1'b0;
      prog_count  <= '0;
      sweep_cnt   <= '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          fetch_valid <= 1'b0;
          sweep_cnt   <= sweep_cnt + 1'b1;
        end
        RUN: begin
          if (prog_en) begin
            fetch_valid <= 1'b0;
          end else if (!stall) begin
            if (fetch_req) begin
              fetch_valid <= 1'b1;
              fetch_err   <= !fetch_ok;
              fetch_data  <= fetch_ok ? mem[fetch_idx] : NOP_WORD;
            end else begin
              fetch_valid <= 1'b0;
            end
          end
        end
        PROG: begin
          fetch_valid <= 1'b0;
          if (prog_we && prog_ok && (prog_count != '1)) prog_count <= prog_count + 16'd1;
        end
        default: fetch_valid <= 1'b0;
      endcase
    end
  end

endmodule
